// File: rtl/w0rm_core_regfile_mp.sv
// W0RM core register file: registered multi-port reads, two write ports, pending scoreboard
// and a sequenced clear. Define W0RM_REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module w0rm_core_regfile_mp #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  NUM_REGISTERS  = 16,
    parameter int  NUM_READ_PORTS = 2,
    parameter int  NUM_USER_BITS  = 64,
    localparam int AW             = $clog2(NUM_REGISTERS),
    localparam int DW             = DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ_PORTS*AW-1:0] rd_addr,
    output logic [NUM_READ_PORTS*DW-1:0] rd_data,
    output logic [NUM_READ_PORTS-1:0]    rd_pending,
    input  logic                         wr0_en,
    input  logic [AW-1:0]                wr0_addr,
    input  logic [DW-1:0]                wr0_data,
    input  logic                         wr1_en,
    input  logic [AW-1:0]                wr1_addr,
    input  logic [DW-1:0]                wr1_data,
    input  logic                         claim_en,
    input  logic [AW-1:0]                claim_addr,
    input  logic                         alu_ready,
    output logic                         reg_file_ready,
    input  logic [NUM_USER_BITS-1:0]     user_data_in,
    output logic [NUM_USER_BITS-1:0]     user_data_out
);

`ifdef W0RM_REGFILE_ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                       state_q;
    logic [AW-1:0]                clr_cnt_q;
    logic [DW-1:0]                regs_q [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0]     pending_q, pending_d;
    logic [NUM_READ_PORTS*DW-1:0] rd_data_q, rd_data_d;
    logic [NUM_READ_PORTS-1:0]    rd_pending_q, rd_pending_d;
    logic [NUM_USER_BITS-1:0]     user_q;
    logic [AW-1:0]                ra;
    logic                         active, wr0_commit, wr1_commit, claim_commit;

    // A wr0 hit on the same register wins, so wr1 never races it into the array.
    assign active       = (state_q == RUN) && !reset;
    assign wr0_commit   = active && wr0_en && !(ZeroReg && wr0_addr == '0);
    assign wr1_commit   = active && wr1_en && !(ZeroReg && wr1_addr == '0)
                          && !(wr0_commit && wr0_addr == wr1_addr);
    assign claim_commit = active && claim_en && !(ZeroReg && claim_addr == '0);

    // A claim outranks a same-cycle write so an in-flight producer stays visible.
    always_comb begin
        pending_d = pending_q;
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            if ((wr0_commit && wr0_addr == AW'(r)) || (wr1_commit && wr1_addr == AW'(r)))
                pending_d[r] = 1'b0;
            if (claim_commit && claim_addr == AW'(r))
                pending_d[r] = 1'b1;
        end
    end

    always_comb begin
        rd_data_d    = '0;
        rd_pending_d = '0;
        ra           = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            ra = rd_addr[p*AW +: AW];
            if (active && !(ZeroReg && ra == '0)) begin
                if (wr0_commit && wr0_addr == ra)
                    rd_data_d[p*DW +: DW] = wr0_data;
                else if (wr1_commit && wr1_addr == ra)
                    rd_data_d[p*DW +: DW] = wr1_data;
                else
                    rd_data_d[p*DW +: DW] = regs_q[ra];
                rd_pending_d[p] = pending_d[ra];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            pending_q    <= '0;
            rd_data_q    <= '0;
            rd_pending_q <= '0;
            user_q       <= '0;
        end else begin
            pending_q    <= pending_d;
            rd_data_q    <= rd_data_d;
            rd_pending_q <= rd_pending_d;
            user_q       <= user_data_in;
            if (state_q == CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(NUM_REGISTERS - 1))
                    state_q <= RUN;
            end
        end
    end

    // The array carries no reset so it can map onto RAM; CLEAR zeroes one entry per cycle.
    always_ff @(posedge clk) begin
        if (!reset && state_q == CLEAR) begin
            regs_q[clr_cnt_q] <= '0;
        end else begin
            if (wr0_commit)
                regs_q[wr0_addr] <= wr0_data;
            if (wr1_commit)
                regs_q[wr1_addr] <= wr1_data;
        end
    end

    assign rd_data        = rd_data_q;
    assign rd_pending     = rd_pending_q;
    assign user_data_out  = user_q;
    assign reg_file_ready = (state_q == RUN) && alu_ready;

endmodule

// File: tb/tb_w0rm_core_regfile_mp.sv
// Self-checking bench for w0rm_core_regfile_mp: expected read results are queued when stimulus
// is driven and popped after the capturing clock edge.
module tb_w0rm_core_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int NP = 2;
    localparam int NU = 64;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic [NP-1:0]     rd_pending;
    logic              wr0_en, wr1_en, claim_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, claim_addr;
    logic [DW-1:0]     wr0_data, wr1_data;
    logic              alu_ready;
    logic              reg_file_ready;
    logic [NU-1:0]     user_data_in, user_data_out;

    typedef struct {
        string       name;
        logic [65:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [65:0] got;
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] model [NR];

    w0rm_core_regfile_mp #(
        .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ_PORTS(NP), .NUM_USER_BITS(NU)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .alu_ready(alu_ready), .reg_file_ready(reg_file_ready),
        .user_data_in(user_data_in), .user_data_out(user_data_out)
    );

    always #5 clk = ~clk;

    // Packs expected port data/pending the same way {rd_data, rd_pending} is laid out.
    function automatic logic [65:0] mk(input logic [31:0] d0, input logic [31:0] d1,
                                       input logic p0, input logic p1);
        return {d1, d0, p1, p0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] a0, input logic [3:0] a1,
                                 input logic w0, input logic [3:0] w0a, input logic [31:0] w0d,
                                 input logic w1, input logic [3:0] w1a, input logic [31:0] w1d,
                                 input logic c, input logic [3:0] ca);
        rd_addr    = {a1, a0};
        wr0_en     = w0;  wr0_addr = w0a;  wr0_data = w0d;
        wr1_en     = w1;  wr1_addr = w1a;  wr1_data = w1d;
        claim_en   = c;   claim_addr = ca;
    endtask

    task automatic test_reset();
        int          n;
        logic [63:0] ud;
        applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        alu_ready    = 1'b1;
        user_data_in = 64'hFEED_FACE_1234_5678;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({rd_data, rd_pending, reg_file_ready} !== 67'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {rd_data, rd_pending, reg_file_ready});
        end
        checks++;
        if (user_data_out !== 64'd0) begin
            fails++;
            $display("[TB] FAIL reset_user: got %h expected 0", user_data_out);
        end
        n = 0;
        while (reg_file_ready !== 1'b1 && n < 40) begin
            ud = {32'hC0DE_0000, 32'(n)};
            user_data_in = ud;
            tick();
            n++;
            checks++;
            if (user_data_out !== ud) begin
                fails++;
                $display("[TB] FAIL clear_user_passthru: got %h expected %h", user_data_out, ud);
            end
        end
        checks++;
        if (n != 16) begin
            fails++;
            $display("[TB] FAIL clear_cycles: got %0d expected 16", n);
        end
        for (int s = 0; s < NR / 2; s++) begin
            applyStimulus(4'(2*s), 4'(2*s+1), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            sb.push_back('{"cleared_regs", mk(32'd0, 32'd0, 1'b0, 1'b0)});
            tick();
            e = sb.pop_front();
            got = {rd_data, rd_pending};
            checks++;
            if (got !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_write_read();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: begin
                    applyStimulus(4'd3, 4'd4, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
                    sb.push_back('{"bypass_wr0", mk(32'hDEADBEEF, 32'd0, 1'b0, 1'b0)});
                end
                1: begin
                    applyStimulus(4'd3, 4'd4, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
                    sb.push_back('{"stored_wr0", mk(32'hDEADBEEF, 32'd0, 1'b0, 1'b0)});
                end
                2: begin
                    applyStimulus(4'd12, 4'd11, 1'b1, 4'd11, 32'hA, 1'b1, 4'd12, 32'hB, 1'b0, 4'd0);
                    sb.push_back('{"bypass_two_writes", mk(32'hB, 32'hA, 1'b0, 1'b0)});
                end
                default: begin
                    applyStimulus(4'd11, 4'd12, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
                    sb.push_back('{"stored_two_writes", mk(32'hA, 32'hB, 1'b0, 1'b0)});
                end
            endcase
            tick();
            e = sb.pop_front();
            got = {rd_data, rd_pending};
            checks++;
            if (got !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_collision();
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin
                    applyStimulus(4'd5, 4'd5, 1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, 4'd0);
                    sb.push_back('{"collision_bypass", mk(32'h11, 32'h11, 1'b0, 1'b0)});
                end
                1: begin
                    applyStimulus(4'd5, 4'd6, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0);
                    sb.push_back('{"collision_stored_wr1_bypass", mk(32'h11, 32'h66, 1'b0, 1'b0)});
                end
                default: begin
                    applyStimulus(4'd6, 4'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
                    sb.push_back('{"collision_stored", mk(32'h66, 32'h11, 1'b0, 1'b0)});
                end
            endcase
            tick();
            e = sb.pop_front();
            got = {rd_data, rd_pending};
            checks++;
            if (got !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_scoreboard();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: begin
                    applyStimulus(4'd7, 4'd8, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7);
                    sb.push_back('{"claim_same_cycle", mk(32'd0, 32'd0, 1'b1, 1'b0)});
                end
                1: begin
                    applyStimulus(4'd7, 4'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
                    sb.push_back('{"claim_held", mk(32'd0, 32'd0, 1'b1, 1'b1)});
                end
                2: begin
                    applyStimulus(4'd7, 4'd9, 1'b1, 4'd9, 32'h9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
                    sb.push_back('{"other_write_keeps_claim", mk(32'd0, 32'h9, 1'b1, 1'b0)});
                end
                3: begin
                    applyStimulus(4'd7, 4'd7, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h55, 1'b0, 4'd0);
                    sb.push_back('{"wr1_clears_pending", mk(32'h55, 32'h55, 1'b0, 1'b0)});
                end
                4: begin
                    applyStimulus(4'd7, 4'd8, 1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7);
                    sb.push_back('{"claim_beats_write", mk(32'h77, 32'd0, 1'b1, 1'b0)});
                end
                default: begin
                    applyStimulus(4'd7, 4'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
                    sb.push_back('{"claim_beats_write_held", mk(32'h77, 32'h77, 1'b1, 1'b1)});
                end
            endcase
            tick();
            e = sb.pop_front();
            got = {rd_data, rd_pending};
            checks++;
            if (got !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_ready();
        alu_ready = 1'b0;
        #1;
        checks++;
        if (reg_file_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ready_follows_alu_low: got %b expected 0", reg_file_ready);
        end
        alu_ready = 1'b1;
        #1;
        checks++;
        if (reg_file_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_follows_alu_high: got %b expected 1", reg_file_ready);
        end
    endtask

    task automatic test_zero_reg();
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin
                    applyStimulus(4'd0, 4'd7, 1'b1, 4'd0, 32'hFFFF, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0);
`ifdef W0RM_REGFILE_ZERO_REG_EN
                    sb.push_back('{"r0_write_claim", mk(32'd0, 32'h77, 1'b0, 1'b1)});
`else
                    sb.push_back('{"r0_write_claim", mk(32'hFFFF, 32'h77, 1'b1, 1'b1)});
`endif
                end
                1: begin
                    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'h1234, 1'b0, 4'd0);
`ifdef W0RM_REGFILE_ZERO_REG_EN
                    sb.push_back('{"r0_wr1", mk(32'd0, 32'd0, 1'b0, 1'b0)});
`else
                    sb.push_back('{"r0_wr1", mk(32'h1234, 32'h1234, 1'b0, 1'b0)});
`endif
                end
                default: begin
                    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
`ifdef W0RM_REGFILE_ZERO_REG_EN
                    sb.push_back('{"r0_stored", mk(32'd0, 32'd0, 1'b0, 1'b0)});
`else
                    sb.push_back('{"r0_stored", mk(32'h1234, 32'h1234, 1'b0, 1'b0)});
`endif
                end
            endcase
            tick();
            e = sb.pop_front();
            got = {rd_data, rd_pending};
            checks++;
            if (got !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int s = 0; s < 2; s++) begin
            if (s == 0)
                applyStimulus(4'd2, 4'd10, 1'b1, 4'd2, 32'h99, 1'b0, 4'd0, 32'd0, 1'b1, 4'd10);
            else
                applyStimulus(4'd2, 4'd10, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            sb.push_back('{"pre_reset_r2", mk(32'h99, 32'd0, 1'b0, 1'b1)});
            tick();
            e = sb.pop_front();
            got = {rd_data, rd_pending};
            checks++;
            if (got !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({rd_data, rd_pending, reg_file_ready} !== 67'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_outputs: got %h expected 0", {rd_data, rd_pending, reg_file_ready});
        end
        for (int k = 0; k < 6; k++) tick();
        applyStimulus(4'd0, 4'd2, 1'b1, 4'd0, 32'hBAD, 1'b1, 4'd1, 32'hCAFE, 1'b1, 4'd1);
        sb.push_back('{"clear_reads_held", mk(32'd0, 32'd0, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front();
        got = {rd_data, rd_pending};
        checks++;
        if (got !== e.val) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        n = 0;
        while (reg_file_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            fails++;
            $display("[TB] FAIL reset_mid_ready_timeout: got %0d cycles expected under 40", n);
        end
        for (int s = 0; s < 2; s++) begin
            if (s == 0)
                applyStimulus(4'd0, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            else
                applyStimulus(4'd1, 4'd10, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            sb.push_back('{"post_reset_lost_writes", mk(32'd0, 32'd0, 1'b0, 1'b0)});
            tick();
            e = sb.pop_front();
            got = {rd_data, rd_pending};
            checks++;
            if (got !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [3:0]  a, prev;
        for (int r = 0; r < NR; r++) model[r] = 32'd0;
        for (int i = 0; i < 8; i++) begin
            a    = 4'(8 + i);
            prev = 4'(7 + i);
            d    = $urandom;
            applyStimulus(a, prev, 1'b1, a, d, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            sb.push_back('{"back_to_back", mk(d, model[prev], 1'b0, 1'b0)});
            model[a] = d;
            tick();
            e = sb.pop_front();
            got = {rd_data, rd_pending};
            checks++;
            if (got !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        alu_ready    = 1'b0;
        user_data_in = '0;
        applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        tick();
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_ready();
        test_zero_reg();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
